// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO dimensions and a compile-time log2 helper.
package fifo_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: storage array with one write port and one registered read port.
module fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    // Array is never reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with occupancy flags, thresholds and sticky error flags.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int AW    = log2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_enb,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_enb,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [AW:0]       af_thresh,
    input  logic [AW:0]       ae_thresh,
    input  logic              clr_err,
    output logic [AW:0]       count,
    output logic              f_full,
    output logic              f_empty,
    output logic              f_almostfull,
    output logic              f_almostempty,
    output logic              f_overrun,
    output logic              f_underrun
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          eff_read, eff_write;

    always_comb begin
        f_full        = count == DEPTH_C;
        f_empty       = count == '0;
        f_almostfull  = count >= af_thresh;
        f_almostempty = count <= ae_thresh;
        eff_read      = rd_enb & ~f_empty;
        eff_write     = wr_enb & (~f_full | eff_read);
    end

    // Error flags stay set when a new error coincides with clr_err.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid   <= 1'b0;
            f_overrun  <= 1'b0;
            f_underrun <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(eff_write);
            rd_ptr     <= rd_ptr + AW'(eff_read);
            count      <= count + (AW+1)'(eff_write) - (AW+1)'(eff_read);
            rd_valid   <= eff_read;
            f_overrun  <= (f_overrun & ~clr_err) | (wr_enb & ~eff_write);
            f_underrun <= (f_underrun & ~clr_err) | (rd_enb & ~eff_read);
        end
    end

    fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk    (clk),
        .resetn (resetn),
        .we     (eff_write),
        .waddr  (wr_ptr),
        .wdata  (wr_data),
        .re     (eff_read),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );
endmodule
